key_freq_ctrl: RTL and testbench
================================

KEY_FREQ_CTRL -- requirements
Module: key_freq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning cycles a synchronised key level must stay stable before acceptance.
REQ-002 SHALL have parameter FW_INIT, default 12'd1, meaning the freq_word value after reset.
REQ-003 SHALL have parameter FW_MIN, default 12'd1, meaning the lowest allowed freq_word.
REQ-004 SHALL have parameter FW_MAX, default 12'd4095, meaning the highest allowed freq_word.
REQ-005 SHALL have parameter FW_STEP, default 12'd1, meaning the increment or decrement applied per accepted press.
REQ-006 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-008 SHALL have port freq_add, input, 1 bit: raw increase key, asynchronous, active-high (pressed = 1).
REQ-009 SHALL have port freq_dec, input, 1 bit: raw decrease key, asynchronous, active-high.
REQ-010 SHALL have port freq_word, output, 12 bits: registered DDS phase-increment word for the downstream address stage.
REQ-011 SHALL have port freq_upd, output, 1 bit: one-cycle pulse, high in the first cycle a new freq_word value is visible.
REQ-012 SHALL have ports at_min and at_max, output, 1 bit each: registered flags, high when freq_word equals FW_MIN or FW_MAX respectively.

Function
REQ-013 SHALL synchronise each key through two flip-flops before any other logic.
REQ-014 SHALL run a per-key debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-015 SHALL go IDLE->PRESS_WAIT when sync=1; PRESS_WAIT->HELD after DEBOUNCE_CYCLES consecutive sync=1; PRESS_WAIT->IDLE on any sync=0.
REQ-016 SHALL go HELD->RELEASE_WAIT when sync=0; RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive sync=0; RELEASE_WAIT->HELD on any sync=1.
REQ-017 SHALL raise a one-cycle press event on the PRESS_WAIT->HELD transition only.
REQ-018 SHALL change freq_word on the clock edge after a press event, giving a total latency of DEBOUNCE_CYCLES+3 cycles from the first sampled-high edge of the raw key.
REQ-019 SHALL set the add result to min(freq_word+FW_STEP, FW_MAX), computed in 13 bits with no wrap-around.
REQ-020 SHALL set the dec result to max(freq_word-FW_STEP, FW_MIN), computed signed with no wrap-around.
REQ-021 SHALL leave freq_word unchanged when add and dec events occur in the same cycle.
REQ-022 SHALL pulse freq_upd only when freq_word actually changes; saturated presses give no pulse.
REQ-023 SHALL make at_min and at_max valid in the same cycle as the freq_word they describe.

Reset
REQ-024 SHALL, while reset=0, force freq_word=FW_INIT, freq_upd=0, both FSMs to IDLE, synchronisers and counters to 0, and repeat timers to 0.
REQ-025 SHALL set at_min=(FW_INIT==FW_MIN) and at_max=(FW_INIT==FW_MAX) during reset.
REQ-026 SHALL discard a key press in progress when reset asserts mid-debounce; after release it needs a full fresh debounce.

Configuration
REQ-027 SHALL, with macro KEY_AUTO_REPEAT_EN defined, generate extra press events while in HELD: the first 2*DEBOUNCE_CYCLES after entry, then one every DEBOUNCE_CYCLES, each stepping as in REQ-019/020.
REQ-028 SHALL, without KEY_AUTO_REPEAT_EN, give exactly one press event per debounced press and synthesise no repeat timers.

Structure
REQ-029 SHALL place the FSM state typedef/localparams, the 12-bit FW_WIDTH constant and the default FW_MIN/FW_MAX/FW_INIT in a shared package also used by the address-calculation stage.
REQ-030 SHALL implement REQ-013..017 and REQ-027 in one sub-module key_debounce, instantiated twice; saturation and flags live in key_freq_ctrl.

Verification (DEBOUNCE_CYCLES=4, FW_INIT=1, FW_MIN=1, FW_MAX=8, FW_STEP=1)
REQ-031 SHALL cover: freq_add high 20 cycles -> freq_word 1->2 exactly 7 cycles after the first high edge, one freq_upd pulse, at_min 1->0.
REQ-032 SHALL cover: freq_add glitch high 3 cycles -> freq_word stays 1, no freq_upd.
REQ-033 SHALL cover: 10 separated debounced adds from 1 -> freq_word saturates at 8, at_max=1, the last 3 presses give no freq_upd; one dec from 1 -> stays 1.
REQ-034 SHALL cover: add and dec asserted on identical cycles -> freq_word unchanged, no freq_upd.
REQ-035 SHALL cover: reset pulsed low mid PRESS_WAIT -> freq_word=1 immediately, no event after reset release until key released and re-pressed.
REQ-036 SHALL cover, with KEY_AUTO_REPEAT_EN: add held 40 cycles from 1 -> steps at cycle 7, then +8 cycles, then every 4 cycles, saturating at 8.

Source files
------------

// File: rtl/key_freq_ctrl_pkg.sv
// Shared constants and key-FSM state type for the key frequency controller
// and the downstream DDS address-calculation stage.
package key_freq_ctrl_pkg;

  localparam int unsigned FW_WIDTH = 12;

  localparam logic [FW_WIDTH-1:0] FW_MIN_DEF  = 12'd1;
  localparam logic [FW_WIDTH-1:0] FW_MAX_DEF  = 12'd4095;
  localparam logic [FW_WIDTH-1:0] FW_INIT_DEF = 12'd1;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS_WAIT,
    KEY_HELD,
    KEY_RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/key_freq_ctrl_if.sv
// Frequency-word bus from the key controller to the DDS address stage.
interface key_freq_ctrl_if import key_freq_ctrl_pkg::*; ();

  logic [FW_WIDTH-1:0] freq_word;
  logic                freq_upd;
  logic                at_min;
  logic                at_max;

  modport master (output freq_word, freq_upd, at_min, at_max);
  modport slave  (input  freq_word, freq_upd, at_min, at_max);

endinterface

// File: rtl/key_freq_ctrl_debounce.sv
// Per-key two-flop synchroniser and debounce FSM producing a one-cycle press event.
// Optional auto-repeat while held is enabled by macro KEY_AUTO_REPEAT_EN.
module key_debounce import key_freq_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic [1:0]       r_vld;
  logic             r_armed;
  key_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_press, w_press_nxt;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(2 * DEBOUNCE_CYCLES + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(2 * DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(DEBOUNCE_CYCLES - 1);
  logic [RW-1:0] r_rpt, w_rpt_nxt;
  logic          r_rpt_first, w_rpt_first_nxt;
`endif

  // A key held across reset stays ignored until it has been seen released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_sync2);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_press_nxt = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    w_rpt_nxt       = '0;
    w_rpt_first_nxt = 1'b1;
`endif
    case (r_state)
      KEY_IDLE: begin
        if (r_sync2 && r_armed) w_state_nxt = KEY_PRESS_WAIT;
      end
      KEY_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = KEY_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = KEY_HELD;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      KEY_HELD: begin
`ifdef KEY_AUTO_REPEAT_EN
        w_rpt_nxt       = r_rpt;
        w_rpt_first_nxt = r_rpt_first;
`endif
        if (!r_sync2) begin
          w_state_nxt = KEY_RELEASE_WAIT;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (r_rpt == (r_rpt_first ? RPT_FIRST : RPT_NEXT)) begin
          w_press_nxt     = 1'b1;
          w_rpt_nxt       = '0;
          w_rpt_first_nxt = 1'b0;
        end else begin
          w_rpt_nxt = r_rpt + 1'b1;
        end
`endif
      end
      KEY_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = KEY_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = KEY_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = KEY_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= KEY_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
`ifdef KEY_AUTO_REPEAT_EN
      r_rpt       <= w_rpt_nxt;
      r_rpt_first <= w_rpt_first_nxt;
`endif
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/key_freq_ctrl.sv
// Two debounced keys step a saturating DDS frequency word up or down.
// Define KEY_AUTO_REPEAT_EN for auto-repeat while a key is held.
module key_freq_ctrl import key_freq_ctrl_pkg::*; #(
  parameter int unsigned         DEBOUNCE_CYCLES = 20000,
  parameter logic [FW_WIDTH-1:0] FW_INIT         = FW_INIT_DEF,
  parameter logic [FW_WIDTH-1:0] FW_MIN          = FW_MIN_DEF,
  parameter logic [FW_WIDTH-1:0] FW_MAX          = FW_MAX_DEF,
  parameter logic [FW_WIDTH-1:0] FW_STEP         = 12'd1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             freq_add,
  input  logic             freq_dec,
  key_freq_ctrl_if.master  fw_bus
);

  logic                       w_add_press, w_dec_press;
  logic [FW_WIDTH:0]          w_sum;
  logic signed [FW_WIDTH+1:0] w_diff;
  logic [FW_WIDTH-1:0]        w_add_res, w_dec_res, w_fw_nxt;
  logic [FW_WIDTH-1:0]        r_fw;
  logic                       r_upd, r_at_min, r_at_max;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
    .i_clk   (sys_clk),
    .i_rst_n (reset),
    .i_key   (freq_add),
    .o_press (w_add_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .i_clk   (sys_clk),
    .i_rst_n (reset),
    .i_key   (freq_dec),
    .o_press (w_dec_press)
  );

  // Widened arithmetic so neither direction can wrap before clamping.
  assign w_sum     = {1'b0, r_fw} + {1'b0, FW_STEP};
  assign w_add_res = (w_sum > {1'b0, FW_MAX}) ? FW_MAX : w_sum[FW_WIDTH-1:0];
  assign w_diff    = $signed({2'b00, r_fw}) - $signed({2'b00, FW_STEP});
  assign w_dec_res = (w_diff < $signed({2'b00, FW_MIN})) ? FW_MIN : w_diff[FW_WIDTH-1:0];

  always_comb begin
    w_fw_nxt = r_fw;
    case ({w_add_press, w_dec_press})
      2'b10:   w_fw_nxt = w_add_res;
      2'b01:   w_fw_nxt = w_dec_res;
      default: w_fw_nxt = r_fw;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_fw     <= FW_INIT;
      r_upd    <= 1'b0;
      r_at_min <= (FW_INIT == FW_MIN);
      r_at_max <= (FW_INIT == FW_MAX);
    end else begin
      r_fw     <= w_fw_nxt;
      r_upd    <= (w_fw_nxt != r_fw);
      r_at_min <= (w_fw_nxt == FW_MIN);
      r_at_max <= (w_fw_nxt == FW_MAX);
    end
  end

  assign fw_bus.freq_word = r_fw;
  assign fw_bus.freq_upd  = r_upd;
  assign fw_bus.at_min    = r_at_min;
  assign fw_bus.at_max    = r_at_max;

endmodule

// File: tb/tb_key_freq_ctrl.sv
// Directed bench for key_freq_ctrl with an expected-update scoreboard.
// Auto-repeat scenarios are included when KEY_AUTO_REPEAT_EN is defined.
module tb_key_freq_ctrl;

  localparam int unsigned D    = 4;
  localparam logic [11:0] FMIN = 12'd1;
  localparam logic [11:0] FMAX = 12'd8;

  logic sys_clk  = 1'b0;
  logic reset    = 1'b0;
  logic freq_add = 1'b0;
  logic freq_dec = 1'b0;

  key_freq_ctrl_if bus ();

  key_freq_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .FW_INIT         (12'd1),
    .FW_MIN          (FMIN),
    .FW_MAX          (FMAX),
    .FW_STEP         (12'd1)
  ) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .freq_add (freq_add),
    .freq_dec (freq_dec),
    .fw_bus   (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic [11:0] w;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [11:0] m_exp       = 12'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_upd(input int at_cyc, input logic [11:0] w);
    exp_t e;
    e.cyc = at_cyc;
    e.w   = w;
    sb.push_back(e);
    m_exp = w;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge sys_clk);
    cyc++;
    #1;
    if (bus.freq_upd === 1'b1) begin
      if (sb.size() == 0) begin
        check("upd_unexpected", 32'(bus.freq_upd), 32'd0);
      end else begin
        e = sb.pop_front();
        check("upd_word", 32'(bus.freq_word), 32'(e.w));
        check("upd_cycle", cyc, e.cyc);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit add, input bit dec, input int hold, input int rel);
    freq_add = add;
    freq_dec = dec;
    ticks(hold);
    freq_add = 1'b0;
    freq_dec = 1'b0;
    ticks(rel);
  endtask

  task automatic settle(input string tag);
    check({tag, "_pending"}, sb.size(), 0);
    check({tag, "_word"},   32'(bus.freq_word), 32'(m_exp));
    check({tag, "_at_min"}, 32'(bus.at_min), 32'(m_exp == FMIN));
    check({tag, "_at_max"}, 32'(bus.at_max), 32'(m_exp == FMAX));
  endtask

  task automatic dec_to_min();
    while (m_exp > FMIN) begin
      expect_upd(cyc + 8, m_exp - 12'd1);
      press(1'b0, 1'b1, 8, 12);
    end
  endtask

  initial begin
    int c;

    ticks(3);
    check("rst_word",   32'(bus.freq_word), 32'd1);
    check("rst_upd",    32'(bus.freq_upd), 32'd0);
    check("rst_at_min", 32'(bus.at_min), 32'd1);
    check("rst_at_max", 32'(bus.at_max), 32'd0);
    reset = 1'b1;
    ticks(6);

    press(1'b1, 1'b0, 3, 12);
    settle("glitch");

    c = cyc;
    expect_upd(c + 8, 12'd2);
`ifdef KEY_AUTO_REPEAT_EN
    expect_upd(c + 16, 12'd3);
    expect_upd(c + 20, 12'd4);
`endif
    press(1'b1, 1'b0, 20, 12);
    settle("add20");

    dec_to_min();
    for (int i = 0; i < 10; i++) begin
      if (m_exp < FMAX) expect_upd(cyc + 8, m_exp + 12'd1);
      press(1'b1, 1'b0, 8, 12);
    end
    settle("sat_max");

    dec_to_min();
    press(1'b0, 1'b1, 8, 12);
    settle("sat_min");

    expect_upd(cyc + 8, 12'd2);
    press(1'b1, 1'b0, 8, 12);
    press(1'b1, 1'b1, 8, 12);
    settle("both");

    freq_add = 1'b1;
    ticks(4);
    reset = 1'b0;
    #1;
    check("midrst_word",   32'(bus.freq_word), 32'd1);
    check("midrst_upd",    32'(bus.freq_upd), 32'd0);
    check("midrst_at_min", 32'(bus.at_min), 32'd1);
    m_exp = 12'd1;
    ticks(2);
    reset = 1'b1;
    ticks(20);
    settle("held_after_rst");
    freq_add = 1'b0;
    ticks(12);
    expect_upd(cyc + 8, 12'd2);
    press(1'b1, 1'b0, 8, 12);
    settle("fresh_press");

`ifdef KEY_AUTO_REPEAT_EN
    dec_to_min();
    c = cyc;
    expect_upd(c + 8, 12'd2);
    for (int k = 0; k < 6; k++) expect_upd(c + 16 + 4 * k, 12'(3 + k));
    press(1'b1, 1'b0, 40, 12);
    settle("repeat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
